// File: rtl/ir_flag_decoder.sv
// Instruction/memory-data/status register bank feeding the control unit.
// Provides the decoded instruction flags, Z/C status bits, register indices and the extended immediate.
module ir_flag_decoder #(
    parameter logic [31:0] IR_RESET = 32'hE1A00000,
    parameter int          CNT_W    = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [31:0]      mem_rdata,
    input  logic             IRwrite,
    input  logic             Mread,
    input  logic             NZCVwrite,
    input  logic [3:0]       alu_nzcv,
    input  logic [1:0]       regdst,
    input  logic             regbdst,
    input  logic [1:0]       immsrc,
    output logic [11:0]      flags,
    output logic             zero,
    output logic             carry,
    output logic [31:0]      ir,
    output logic [31:0]      mdr,
    output logic [3:0]       ra_idx,
    output logic [3:0]       rb_idx,
    output logic [3:0]       rw_idx,
    output logic [31:0]      ext_imm,
    output logic [CNT_W-1:0] instr_cnt
);

    logic [31:0]      ir_q, ir_d;
    logic [31:0]      mdr_q, mdr_d;
    logic [3:0]       nzcv_q, nzcv_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // 8-bit immediate rotated right by twice the 4-bit rotate field.
    function automatic logic [31:0] rot_imm(input logic [7:0] imm8, input logic [3:0] rot);
        logic [63:0] dbl;
        logic [4:0]  amt;
        amt = {rot, 1'b0};
        dbl = {24'b0, imm8, 24'b0, imm8} >> amt;
        return dbl[31:0];
    endfunction

    always_comb begin
        ir_d   = ir_q;
        mdr_d  = mdr_q;
        nzcv_d = nzcv_q;
        cnt_d  = cnt_q;
        if (IRwrite) begin
            ir_d  = mem_rdata;
            cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
        if (Mread) begin
            mdr_d = mem_rdata;
        end
        if (NZCVwrite) begin
            nzcv_d = alu_nzcv;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ir_q   <= IR_RESET;
            mdr_q  <= 32'h0;
            nzcv_q <= 4'b0000;
            cnt_q  <= '0;
        end else begin
            ir_q   <= ir_d;
            mdr_q  <= mdr_d;
            nzcv_q <= nzcv_d;
            cnt_q  <= cnt_d;
        end
    end

    // N and V are held for completeness of the status register but not exported.
    logic unused_nv;
    assign unused_nv = &{1'b0, nzcv_q[3], nzcv_q[0]};

    assign ir        = ir_q;
    assign mdr       = mdr_q;
    assign instr_cnt = cnt_q;
    assign zero      = nzcv_q[2];
    assign carry     = nzcv_q[1];
    assign ra_idx    = ir_q[19:16];
    assign flags     = {ir_q[31:28], (ir_q[27:25] == 3'b101), (ir_q[27:26] == 2'b01), ir_q[25:20]};

    always_comb begin
        rw_idx = ir_q[15:12];
        case (regdst)
            2'b00:   rw_idx = ir_q[15:12];
            2'b01:   rw_idx = ir_q[19:16];
            2'b10:   rw_idx = 4'd14;
            2'b11:   rw_idx = 4'd15;
            default: rw_idx = ir_q[15:12];
        endcase
    end

    assign rb_idx = regbdst ? ir_q[15:12] : ir_q[3:0];

    always_comb begin
        ext_imm = 32'h0;
        case (immsrc)
            2'b00:   ext_imm = rot_imm(ir_q[7:0], ir_q[11:8]);
            2'b01:   ext_imm = {20'b0, ir_q[11:0]};
            2'b10:   ext_imm = {{6{ir_q[23]}}, ir_q[23:0], 2'b00};
            default: ext_imm = 32'h0;
        endcase
    end

endmodule

// File: tb/tb_ir_flag_decoder.sv
// Bench for ir_flag_decoder: decode vectors through a scoreboard queue, then status, MDR,
// asynchronous reset and counter-wrap sequences (second instance with a 4-bit counter).
module tb_ir_flag_decoder;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] mem_rdata;
    logic        IRwrite, Mread, NZCVwrite;
    logic [3:0]  alu_nzcv;
    logic [1:0]  regdst;
    logic        regbdst;
    logic [1:0]  immsrc;

    logic [11:0] flags;
    logic        zero, carry;
    logic [31:0] ir, mdr, ext_imm;
    logic [3:0]  ra_idx, rb_idx, rw_idx;
    logic [15:0] instr_cnt;

    logic [11:0] flags4;
    logic        zero4, carry4;
    logic [31:0] ir4, mdr4, ext_imm4;
    logic [3:0]  ra4, rb4, rw4;
    logic [3:0]  instr_cnt4;

    int total  = 0;
    int passed = 0;
    int cnt16  = 0;
    int cnt4   = 0;

    always #5 clk = ~clk;

    ir_flag_decoder #(.IR_RESET(32'hE1A00000), .CNT_W(16)) u_dut (
        .clk(clk), .reset(reset), .mem_rdata(mem_rdata), .IRwrite(IRwrite), .Mread(Mread),
        .NZCVwrite(NZCVwrite), .alu_nzcv(alu_nzcv), .regdst(regdst), .regbdst(regbdst),
        .immsrc(immsrc), .flags(flags), .zero(zero), .carry(carry), .ir(ir), .mdr(mdr),
        .ra_idx(ra_idx), .rb_idx(rb_idx), .rw_idx(rw_idx), .ext_imm(ext_imm), .instr_cnt(instr_cnt)
    );

    ir_flag_decoder #(.IR_RESET(32'hE1A00000), .CNT_W(4)) u_dut4 (
        .clk(clk), .reset(reset), .mem_rdata(mem_rdata), .IRwrite(IRwrite), .Mread(Mread),
        .NZCVwrite(NZCVwrite), .alu_nzcv(alu_nzcv), .regdst(regdst), .regbdst(regbdst),
        .immsrc(immsrc), .flags(flags4), .zero(zero4), .carry(carry4), .ir(ir4), .mdr(mdr4),
        .ra_idx(ra4), .rb_idx(rb4), .rw_idx(rw4), .ext_imm(ext_imm4), .instr_cnt(instr_cnt4)
    );

    typedef struct {
        logic [31:0] instr;
        logic [1:0]  rd;
        logic        rbd;
        logic [1:0]  isrc;
        logic [11:0] e_flags;
        logic [3:0]  e_ra;
        logic [3:0]  e_rb;
        logic [3:0]  e_rw;
        logic [31:0] e_imm;
    } vec_t;

    typedef struct {
        logic [11:0] flags;
        logic [3:0]  ra;
        logic [3:0]  rb;
        logic [3:0]  rw;
        logic [31:0] imm;
        logic [31:0] cnt;
    } exp_t;

    vec_t vecs[9];
    exp_t sb[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        IRwrite   = 1'b0;
        Mread     = 1'b0;
        NZCVwrite = 1'b0;
    endtask

    initial begin
        exp_t e;
        vecs[0] = '{32'hEA000002, 2'b00, 1'b0, 2'b10, 12'hEA0, 4'h0, 4'h2, 4'h0, 32'h00000008};
        vecs[1] = '{32'hEAFFFFFE, 2'b00, 1'b0, 2'b10, 12'hEAF, 4'hF, 4'hE, 4'hF, 32'hFFFFFFF8};
        vecs[2] = '{32'hE5912004, 2'b00, 1'b0, 2'b01, 12'hE59, 4'h1, 4'h4, 4'h2, 32'h00000004};
        vecs[3] = '{32'hE5912004, 2'b01, 1'b1, 2'b11, 12'hE59, 4'h1, 4'h2, 4'h1, 32'h00000000};
        vecs[4] = '{32'hE3A004FF, 2'b10, 1'b0, 2'b00, 12'hE3A, 4'h0, 4'hF, 4'hE, 32'hFF000000};
        vecs[5] = '{32'hE3A004FF, 2'b11, 1'b0, 2'b00, 12'hE3A, 4'h0, 4'hF, 4'hF, 32'hFF000000};
        vecs[6] = '{32'hE3A000AB, 2'b00, 1'b0, 2'b00, 12'hE3A, 4'h0, 4'hB, 4'h0, 32'h000000AB};
        vecs[7] = '{32'hE3A001FF, 2'b00, 1'b0, 2'b00, 12'hE3A, 4'h0, 4'hF, 4'h0, 32'hC000003F};
        vecs[8] = '{32'hE3A001FF, 2'b00, 1'b0, 2'b01, 12'hE3A, 4'h0, 4'hF, 4'h0, 32'h000001FF};

        reset = 1'b1; mem_rdata = 32'h0; alu_nzcv = 4'h0;
        regdst = 2'b00; regbdst = 1'b0; immsrc = 2'b00;
        idle_inputs();
        #3;
        chk("rst_flags", {20'h0, flags}, 32'h00000E1A);
        chk("rst_ir", ir, 32'hE1A00000);
        chk("rst_zero", {31'h0, zero}, 32'h0);
        chk("rst_carry", {31'h0, carry}, 32'h0);
        chk("rst_mdr", mdr, 32'h0);
        chk("rst_cnt", {16'h0, instr_cnt}, 32'h0);
        @(negedge clk);
        reset = 1'b0;
        #4;

        // Decode table through the scoreboard.
        for (int i = 0; i < 9; i++) begin
            mem_rdata = vecs[i].instr;
            regdst    = vecs[i].rd;
            regbdst   = vecs[i].rbd;
            immsrc    = vecs[i].isrc;
            IRwrite   = 1'b1;
            cnt16++;
            sb.push_back('{vecs[i].e_flags, vecs[i].e_ra, vecs[i].e_rb, vecs[i].e_rw,
                           vecs[i].e_imm, 32'(cnt16)});
            step();
            IRwrite   = 1'b0;
            mem_rdata = 32'h12345678;
            e = sb.pop_front();
            chk($sformatf("v%0d_flags", i), {20'h0, flags}, {20'h0, e.flags});
            chk($sformatf("v%0d_ra", i), {28'h0, ra_idx}, {28'h0, e.ra});
            chk($sformatf("v%0d_rb", i), {28'h0, rb_idx}, {28'h0, e.rb});
            chk($sformatf("v%0d_rw", i), {28'h0, rw_idx}, {28'h0, e.rw});
            chk($sformatf("v%0d_imm", i), ext_imm, e.imm);
            chk($sformatf("v%0d_cnt", i), {16'h0, instr_cnt}, e.cnt);
        end

        // Held IR with no enable: ir and count hold even when controls are don't-care.
        regdst = 2'bxx; immsrc = 2'bxx; regbdst = 1'bx;
        step();
        step();
        chk("hold_ir", ir, 32'hE3A001FF);
        chk("hold_cnt", {16'h0, instr_cnt}, 32'(cnt16));
        regdst = 2'b00; immsrc = 2'b01; regbdst = 1'b0;

        // Mread alone loads MDR and leaves IR untouched.
        mem_rdata = 32'hDEADBEEF;
        Mread = 1'b1;
        step();
        Mread = 1'b0;
        mem_rdata = 32'h0;
        chk("mdr_load", mdr, 32'hDEADBEEF);
        chk("mdr_ir_hold", ir, 32'hE3A001FF);

        // NZCV written in the same cycle as IR.
        mem_rdata = 32'hE5912004;
        alu_nzcv  = 4'b0110;
        IRwrite   = 1'b1;
        NZCVwrite = 1'b1;
        cnt16++;
        step();
        idle_inputs();
        alu_nzcv = 4'b1001;
        chk("nzcv_zero", {31'h0, zero}, 32'h1);
        chk("nzcv_carry", {31'h0, carry}, 32'h1);
        chk("nzcv_flags", {20'h0, flags}, 32'h00000E59);
        step();
        chk("nzcv_hold_zero", {31'h0, zero}, 32'h1);
        chk("nzcv_hold_carry", {31'h0, carry}, 32'h1);
        NZCVwrite = 1'b1;
        alu_nzcv  = 4'b1011;
        step();
        NZCVwrite = 1'b0;
        chk("nzcv_new_zero", {31'h0, zero}, 32'h0);
        chk("nzcv_new_carry", {31'h0, carry}, 32'h1);
        NZCVwrite = 1'b1;
        alu_nzcv  = 4'b0100;
        step();
        NZCVwrite = 1'b0;

        // Asynchronous reset between clock edges.
        #2;
        reset = 1'b1;
        #1;
        chk("arst_flags", {20'h0, flags}, 32'h00000E1A);
        chk("arst_zero", {31'h0, zero}, 32'h0);
        chk("arst_carry", {31'h0, carry}, 32'h0);
        chk("arst_mdr", mdr, 32'h0);
        chk("arst_cnt", {16'h0, instr_cnt}, 32'h0);
        chk("arst_cnt4", {28'h0, instr_cnt4}, 32'h0);
        #1;
        reset = 1'b0;
        cnt16 = 0;
        cnt4  = 0;

        // Counter wrap on the 4-bit instance.
        mem_rdata = 32'hE1A00000;
        IRwrite   = 1'b1;
        for (int k = 0; k < 15; k++) begin
            step();
            cnt16++;
            cnt4 = (cnt4 + 1) % 16;
        end
        chk("cnt4_15", {28'h0, instr_cnt4}, 32'(cnt4));
        chk("cnt4_is15", {28'h0, instr_cnt4}, 32'd15);
        step();
        cnt16++;
        cnt4 = (cnt4 + 1) % 16;
        IRwrite = 1'b0;
        chk("cnt4_wrap", {28'h0, instr_cnt4}, 32'd0);
        chk("cnt16_16", {16'h0, instr_cnt}, 32'(cnt16));
        step();
        step();
        chk("cnt4_hold", {28'h0, instr_cnt4}, 32'(cnt4));
        chk("cnt16_hold", {16'h0, instr_cnt}, 32'd16);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
